// File: rtl/ncl_counter_sequencer_pkg.sv
// Shared types and dual-rail helper functions for the NCL counter sequencer.
// Rail vectors are zero-padded to DR_MAX_DIGITS digits; n selects how many digits count.
package ncl_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    REQ_NULL  = 2'd2,
    ERROR     = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  localparam int unsigned DR_MAX_DIGITS = 66;
  typedef logic [2*DR_MAX_DIGITS-1:0] dr_vec_t;
  typedef logic [DR_MAX_DIGITS-1:0]   dr_bin_t;

  function automatic logic [1:0] dr_digit(input dr_vec_t v, input int unsigned i);
    return 2'(v >> (2 * i));
  endfunction

  function automatic logic dr_all_data(input dr_vec_t v, input int unsigned n);
    logic ok;
    logic [1:0] d;
    ok = 1'b1;
    for (int unsigned i = 0; i < DR_MAX_DIGITS; i++) begin
      d  = dr_digit(v, i);
      ok = ok & ((i >= n) | (d[0] ^ d[1]));
    end
    return ok;
  endfunction

  function automatic logic dr_all_null(input dr_vec_t v, input int unsigned n);
    logic ok;
    logic [1:0] d;
    ok = 1'b1;
    for (int unsigned i = 0; i < DR_MAX_DIGITS; i++) begin
      d  = dr_digit(v, i);
      ok = ok & ((i >= n) | (d == 2'b00));
    end
    return ok;
  endfunction

  function automatic logic dr_illegal(input dr_vec_t v, input int unsigned n);
    logic bad;
    logic [1:0] d;
    bad = 1'b0;
    for (int unsigned i = 0; i < DR_MAX_DIGITS; i++) begin
      d   = dr_digit(v, i);
      bad = bad | ((i < n) & (d == 2'b11));
    end
    return bad;
  endfunction

  function automatic dr_bin_t dr_to_bin(input dr_vec_t v, input int unsigned n);
    dr_bin_t b;
    logic [1:0] d;
    b = '0;
    for (int unsigned i = 0; i < DR_MAX_DIGITS; i++) begin
      d = dr_digit(v, i);
      b = b | (dr_bin_t'(d[1] & (i < n)) << i);
    end
    return b;
  endfunction

endpackage

// File: rtl/ncl_counter_sequencer_if.sv
// Ring-side dual-rail handshake plus the clocked value stream toward the consumer.
interface ncl_counter_sequencer_if #(parameter int unsigned WIDTH = 32);
  logic [2*WIDTH-1:0] sum_dr;
  logic [1:0]         carry_dr;
  logic               sum_ack;
  logic               carry_ack;
  logic               cnt_valid;
  logic               cnt_ready;
  logic [WIDTH-1:0]   cnt_value;
  logic               cnt_ovf;

  modport master (
    input  sum_dr, carry_dr, cnt_ready,
    output sum_ack, carry_ack, cnt_valid, cnt_value, cnt_ovf
  );

  modport slave (
    output sum_dr, carry_dr, cnt_ready,
    input  sum_ack, carry_ack, cnt_valid, cnt_value, cnt_ovf
  );
endinterface

// File: rtl/ncl_counter_sequencer_sync_detect.sv
// Synchronises every sum/carry rail into clk and reports completeness once it has held
// for two consecutive synchronised samples; the carry is treated as an extra digit.
module ncl_dr_sync_detect
  import ncl_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               init,
  input  logic [2*WIDTH-1:0] sum_dr,
  input  logic [1:0]         carry_dr,
  output logic               all_data,
  output logic               all_null,
  output logic               illegal,
  output logic [WIDTH-1:0]   value,
  output logic               ovf
);
  localparam int unsigned NR = 2 * WIDTH + 2;

  logic [SYNC_STAGES-1:0][NR-1:0] sync_r;
  logic [NR-1:0] smp_s;
  logic data_now_s, null_now_s, ill_now_s;
  logic data_q_r, null_q_r, ill_q_r;

  // rail synchroniser chain, newest sample enters at stage 0
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], {carry_dr, sum_dr}};
    end
  end

  assign smp_s      = sync_r[SYNC_STAGES-1];
  assign data_now_s = dr_all_data(dr_vec_t'(smp_s), WIDTH + 1);
  assign null_now_s = dr_all_null(dr_vec_t'(smp_s), WIDTH + 1);
  assign ill_now_s  = dr_illegal(dr_vec_t'(smp_s), WIDTH + 1);

  // previous-sample flags for the two-sample stability filter
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      data_q_r <= 1'b0;
      null_q_r <= 1'b0;
      ill_q_r  <= 1'b0;
    end else begin
      data_q_r <= data_now_s;
      null_q_r <= null_now_s;
      ill_q_r  <= ill_now_s;
    end
  end

  assign all_data = data_now_s & data_q_r;
  assign all_null = null_now_s & null_q_r;
  assign illegal  = ill_now_s & ill_q_r;
  assign value    = WIDTH'(dr_to_bin(dr_vec_t'(smp_s), WIDTH));
  assign ovf      = smp_s[NR-1];
endmodule

// File: rtl/ncl_counter_sequencer.sv
// Clocked master for the dual-rail NCL counter ring: alternates DATA/NULL wavefronts,
// buffers each DATA value for a valid/ready consumer, and traps timeouts and illegal rails.
module ncl_counter_sequencer
  import ncl_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                     clk,
  input  logic                     init,
  ncl_counter_sequencer_if.master  bus,
  input  logic                     run,
  input  logic                     step,
  input  logic [WIDTH-1:0]         target,
  input  logic                     target_en,
  output logic                     hit,
  output logic                     busy,
  output logic [1:0]               err
);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t state_r, next_state_s;
  logic all_data_s, all_null_s, ill_s, ovf_s;
  logic [WIDTH-1:0] value_s;
  logic run_d_r, run_rise_s, step_mode_r, hit_flag_r;
  logic [WD_W-1:0] wd_r;
  logic waiting_s, stall_s, wd_expired_s, buf_free_s, latch_s, hit_now_s;
  logic ack_r, busy_r, valid_r, ovf_r, hit_r;
  logic [WIDTH-1:0] value_r;
  logic [1:0] err_r, err_next_s;
  logic ack_next_s, busy_next_s;

  ncl_dr_sync_detect #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_detect (
    .clk      (clk),
    .init     (init),
    .sum_dr   (bus.sum_dr),
    .carry_dr (bus.carry_dr),
    .all_data (all_data_s),
    .all_null (all_null_s),
    .illegal  (ill_s),
    .value    (value_s),
    .ovf      (ovf_s)
  );

  assign run_rise_s   = run & ~run_d_r;
  assign waiting_s    = (state_r == WAIT_DATA) || (state_r == REQ_NULL);
  assign buf_free_s   = ~valid_r | bus.cnt_ready;
  assign stall_s      = (state_r == WAIT_DATA) && all_data_s && !buf_free_s;
  assign wd_expired_s = waiting_s && (wd_r == WD_LAST) && !stall_s;
  assign latch_s      = (state_r == WAIT_DATA) && (next_state_s == REQ_NULL);
  assign hit_now_s    = target_en && (value_s == target);

  // state register
  always_ff @(posedge clk or posedge init) begin
    if (init) state_r <= IDLE;
    else      state_r <= next_state_s;
  end

  // next-state decode; an illegal rail pair overrides everything
  always_comb begin
    next_state_s = state_r;
    if (ill_s) begin
      next_state_s = ERROR;
    end else begin
      case (state_r)
        IDLE: begin
          if ((run_rise_s || step) && all_null_s) next_state_s = WAIT_DATA;
          else                                    next_state_s = IDLE;
        end
        WAIT_DATA: begin
          if (wd_expired_s)                  next_state_s = ERROR;
          else if (all_data_s && buf_free_s) next_state_s = REQ_NULL;
          else                               next_state_s = WAIT_DATA;
        end
        REQ_NULL: begin
          if (wd_expired_s)                              next_state_s = ERROR;
          else if (!all_null_s)                          next_state_s = REQ_NULL;
          else if (step_mode_r || hit_flag_r || !run)    next_state_s = IDLE;
          else                                           next_state_s = WAIT_DATA;
        end
        ERROR:   next_state_s = ERROR;
        default: next_state_s = ERROR;
      endcase
    end
  end

  // output decode from the upcoming state so the registered outputs track it
  always_comb begin
    ack_next_s  = 1'b1;
    busy_next_s = 1'b0;
    err_next_s  = err_r;
    case (next_state_s)
      WAIT_DATA: begin ack_next_s = 1'b0; busy_next_s = 1'b1; end
      REQ_NULL:  begin ack_next_s = 1'b1; busy_next_s = 1'b1; end
      IDLE:      begin ack_next_s = 1'b1; busy_next_s = 1'b0; end
      ERROR:     begin ack_next_s = 1'b1; busy_next_s = 1'b0; end
      default:   begin ack_next_s = 1'b1; busy_next_s = 1'b0; end
    endcase
    if (ill_s)             err_next_s = ERR_ILLEGAL;
    else if (wd_expired_s) err_next_s = ERR_TIMEOUT;
    else                   err_next_s = err_r;
  end

  // run edge detect, step/free-run mode, and per-phase watchdog
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      run_d_r     <= 1'b0;
      step_mode_r <= 1'b0;
      wd_r        <= '0;
    end else begin
      run_d_r <= run;
      if (state_r == IDLE && next_state_s == WAIT_DATA) step_mode_r <= ~run_rise_s;
      else                                              step_mode_r <= step_mode_r;
      if (!waiting_s || next_state_s != state_r) wd_r <= '0;
      else if (stall_s)                          wd_r <= wd_r;
      else                                       wd_r <= wd_r + WD_W'(1'b1);
    end
  end

  // registered handshake/status outputs and the single-entry value buffer
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      ack_r      <= 1'b1;
      busy_r     <= 1'b0;
      err_r      <= ERR_NONE;
      valid_r    <= 1'b0;
      value_r    <= '0;
      ovf_r      <= 1'b0;
      hit_r      <= 1'b0;
      hit_flag_r <= 1'b0;
    end else begin
      ack_r  <= ack_next_s;
      busy_r <= busy_next_s;
      err_r  <= err_next_s;
      hit_r  <= latch_s & hit_now_s;
      if (latch_s) begin
        valid_r    <= 1'b1;
        value_r    <= value_s;
        ovf_r      <= ovf_s;
        hit_flag_r <= hit_now_s;
      end else if (valid_r && bus.cnt_ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign bus.sum_ack   = ack_r;
  assign bus.carry_ack = ack_r;
  assign bus.cnt_valid = valid_r;
  assign bus.cnt_value = value_r;
  assign bus.cnt_ovf   = ovf_r;
  assign hit           = hit_r;
  assign busy          = busy_r;
  assign err           = err_r;
endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// Directed bench: a behavioural NCL counter ring answers the acknowledges, a monitor
// logs every accepted value, and the main sequence checks against hand-computed values.
module tb_ncl_counter_sequencer;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 1023;

  logic clk = 1'b0;
  logic init, run, step, target_en, hit, busy;
  logic [W-1:0] target;
  logic [1:0] err;

  ncl_counter_sequencer_if #(.WIDTH(W)) bus ();

  ncl_counter_sequencer #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .init(init), .bus(bus), .run(run), .step(step),
    .target(target), .target_en(target_en), .hit(hit), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    logic [W-1:0] vv;
    r  = '0;
    vv = v;
    for (int i = 0; i < W; i++) begin
      r  = {r[2*W-3:0], vv[W-1], ~vv[W-1]};
      vv = vv << 1;
    end
    return r;
  endfunction

  // ring model controls, written only by the main sequence
  logic [W-1:0] m_load = '0;
  logic stuck7 = 1'b0;
  logic ill3 = 1'b0;

  // behavioural ring: answers each ack phase after a few cycles, counts on each NULL
  initial begin
    logic [W-1:0] m_val;
    logic m_ovf, r_data;
    int dly;
    m_val = '0; m_ovf = 1'b0; r_data = 1'b0; dly = 0;
    bus.sum_dr = '0; bus.carry_dr = 2'b00;
    forever begin
      @(negedge clk);
      if (init) begin
        m_val = m_load; m_ovf = 1'b0; r_data = 1'b0; dly = 0;
        bus.sum_dr = '0; bus.carry_dr = 2'b00;
      end else if (!bus.sum_ack && !r_data) begin
        dly++;
        if (dly >= 3) begin
          dly = 0; r_data = 1'b1;
          bus.sum_dr   = enc(m_val);
          bus.carry_dr = m_ovf ? 2'b10 : 2'b01;
          if (stuck7) bus.sum_dr[15:14] = 2'b00;
        end
      end else if (bus.sum_ack && r_data) begin
        dly++;
        if (dly >= 3) begin
          dly = 0; r_data = 1'b0;
          bus.sum_dr = '0; bus.carry_dr = 2'b00;
          m_ovf = (m_val == 32'hFFFF_FFFF);
          m_val = m_val + 32'd1;
        end
      end else begin
        dly = 0;
      end
      if (ill3) bus.sum_dr[7:6] = 2'b11;
    end
  end

  // consumer-side monitor
  logic [W:0] got_q[$];
  int ack_falls = 0, hits = 0, carry_mism = 0;
  logic [W-1:0] hit_val = '0;
  initial begin
    logic ack_prev;
    ack_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.cnt_valid && bus.cnt_ready) got_q.push_back({bus.cnt_ovf, bus.cnt_value});
      if (hit) begin hits++; hit_val = bus.cnt_value; end
      if (ack_prev && !bus.sum_ack) ack_falls++;
      if (bus.carry_ack !== bus.sum_ack) carry_mism++;
      ack_prev = bus.sum_ack;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    @(posedge clk); #1 init = 1'b1;
    cycles(3);
    init = 1'b0;
    cycles(5);
  endtask

  initial begin
    int n0, a0, h0, c;
    logic [W:0] last;
    logic [W-1:0] base;
    init = 1'b1; run = 1'b0; step = 1'b0; target = '0; target_en = 1'b0;
    bus.cnt_ready = 1'b1;
    cycles(3);
    check_eq("rst_sum_ack", bus.sum_ack, 1);
    check_eq("rst_carry_ack", bus.carry_ack, 1);
    check_eq("rst_valid", bus.cnt_valid, 0);
    check_eq("rst_value", bus.cnt_value, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    init = 1'b0;
    cycles(5);

    // free run with a 200-cycle consumer stall on value 2
    n0 = got_q.size(); a0 = ack_falls;
    run = 1'b1;
    for (int i = 0; i < 500 && got_q.size() < n0 + 2; i++) @(negedge clk);
    check_eq("t1_busy", busy, 1);
    @(posedge clk); #1 bus.cnt_ready = 1'b0;
    cycles(200);
    check_eq("t2_stall_ack", bus.sum_ack, 0);
    check_eq("t2_stall_err", err, 0);
    check_eq("t2_stall_valid", bus.cnt_valid, 1);
    check_eq("t2_stall_value", bus.cnt_value, 2);
    check_eq("t2_stall_count", got_q.size(), n0 + 2);
    bus.cnt_ready = 1'b1;
    for (int i = 0; i < 500 && got_q.size() < n0 + 4; i++) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    cycles(10);
    for (int k = 0; k < 4; k++) check_eq("t1_value", got_q[n0 + k], 33'(k));
    check_eq("t1_ack_per_value", ack_falls - a0, got_q.size() - n0);

    // single step; a second step during REQ_NULL must be ignored
    n0 = got_q.size();
    last = got_q[n0 - 1];
    base = last[W-1:0] + 32'd1;
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    for (int i = 0; i < 300 && !(bus.sum_ack && busy); i++) @(negedge clk);
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    cycles(30);
    check_eq("t3_count", got_q.size(), n0 + 1);
    check_eq("t3_value", got_q[n0], {1'b0, base});
    check_eq("t3_ack", bus.sum_ack, 1);
    check_eq("t3_busy", busy, 0);

    // stop on target 5, then a fresh run edge resumes at 6
    m_load = '0;
    pulse_init();
    target = 32'd5; target_en = 1'b1;
    n0 = got_q.size(); h0 = hits;
    run = 1'b1;
    for (int i = 0; i < 1000 && got_q.size() < n0 + 6; i++) @(negedge clk);
    cycles(40);
    check_eq("t4_count", got_q.size(), n0 + 6);
    for (int k = 0; k < 6; k++) check_eq("t4_value", got_q[n0 + k], 33'(k));
    check_eq("t4_hit_count", hits - h0, 1);
    check_eq("t4_hit_value", hit_val, 5);
    check_eq("t4_idle_busy", busy, 0);
    check_eq("t4_idle_ack", bus.sum_ack, 1);
    run = 1'b0;
    cycles(1);
    run = 1'b1;
    for (int i = 0; i < 300 && got_q.size() < n0 + 7; i++) @(negedge clk);
    check_eq("t4_resume", got_q[n0 + 6], 33'd6);
    run = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    target_en = 1'b0;

    // wrap from all ones with carry DATA1
    m_load = 32'hFFFF_FFFF;
    pulse_init();
    n0 = got_q.size();
    run = 1'b1;
    for (int i = 0; i < 500 && got_q.size() < n0 + 2; i++) @(negedge clk);
    run = 1'b0;
    check_eq("t5_max", got_q[n0], {1'b0, 32'hFFFF_FFFF});
    check_eq("t5_wrap", got_q[n0 + 1], {1'b1, 32'h0000_0000});
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);

    // watchdog timeout, then illegal rails
    m_load = '0; stuck7 = 1'b1;
    pulse_init();
    run = 1'b1;
    for (c = 0; c < 1300 && err == 2'd0; c++) @(negedge clk);
    check_eq("t6_timeout_err", err, 1);
    check_eq("t6_timeout_lat", (c >= TMO - 8 && c <= TMO + 8), 1);
    check_eq("t6_timeout_ack", bus.sum_ack, 1);
    check_eq("t6_timeout_busy", busy, 0);
    ill3 = 1'b1;
    for (int i = 0; i < 30 && err != 2'd2; i++) @(negedge clk);
    check_eq("t6_illegal_err", err, 2);
    check_eq("t6_illegal_ack", bus.sum_ack, 1);
    run = 1'b0; ill3 = 1'b0; stuck7 = 1'b0;
    m_load = 32'h0000_1234;
    pulse_init();
    check_eq("t6_init_clears_err", err, 0);

    // async init while stalled in WAIT_DATA with a pending value
    bus.cnt_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 300 && !bus.cnt_valid; i++) @(negedge clk);
    cycles(20);
    check_eq("t6_pre_busy", busy, 1);
    check_eq("t6_pre_ack", bus.sum_ack, 0);
    check_eq("t6_pre_value", bus.cnt_value, 32'h0000_1234);
    @(posedge clk); #2 init = 1'b1;
    #1;
    check_eq("t6_async_valid", bus.cnt_valid, 0);
    check_eq("t6_async_value", bus.cnt_value, 0);
    check_eq("t6_async_ovf", bus.cnt_ovf, 0);
    check_eq("t6_async_busy", busy, 0);
    check_eq("t6_async_err", err, 0);
    check_eq("t6_async_ack", bus.sum_ack, 1);
    check_eq("t6_async_carry_ack", bus.carry_ack, 1);
    run = 1'b0;
    cycles(3);
    check_eq("carry_ack_tracks", carry_mism, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ncl_counter_sequencer.md
Name: ncl_counter_sequencer

Overview:
- Clocked master controller for the 32-bit dual-rail NCL counter ring array.
- Synchronises the ring's dual-rail sum and MSB carry-out wavefronts into the `clk` domain and drives their completeness acknowledges.
- Alternates the ring between DATA and NULL; converts each DATA wavefront to binary and hands it to a clocked consumer over valid/ready.
- Supports free-run, single-step, stop-on-target, backpressure stall and watchdog error detection.

Parameters:
- WIDTH, 32: number of counter digits (dual-rail bits).
- SYNC_STAGES, 2: flop depth of the rail synchronisers (minimum 2).
- TIMEOUT, 1023: maximum `clk` cycles allowed in one handshake phase before an error is raised.

Ports:
- clk  in  1  single system clock.
- init  in  1  asynchronous active-high reset; the same net initialises the NCL ring.
- sum_dr  in  2*WIDTH  dual-rail sum digits; bit i: rail0=[2i], rail1=[2i+1].
- carry_dr  in  2  dual-rail carry-out of the MSB digit stage.
- sum_ack  out  1  completeness acknowledge broadcast to all stage sumcomp inputs; 1 = request NULL, 0 = request DATA.
- carry_ack  out  1  acknowledge to the MSB carrycomp; always equal to sum_ack.
- run  in  1  level: free-run enable.
- step  in  1  one-cycle pulse: run exactly one wavefront.
- target  in  WIDTH  stop value.
- target_en  in  1  enables stop-on-target.
- cnt_valid  out  1  output buffer holds a value.
- cnt_ready  in  1  consumer accepts the value.
- cnt_value  out  WIDTH  binary counter value.
- cnt_ovf  out  1  carry-out was DATA1 in this wavefront.
- hit  out  1  one-cycle pulse when the latched value equals target (with target_en=1).
- busy  out  1  state is not IDLE or ERROR.
- err  out  2  0=none, 1=TIMEOUT, 2=ILLEGAL (rails 2'b11 on any digit); sticky.

Behaviour:
- Reset (async on init=1): state IDLE, sum_ack=carry_ack=1 (ring held at NULL), cnt_valid=0, cnt_value=0, cnt_ovf=0, hit=0, busy=0, err=0, synchronisers cleared, watchdog=0.
- Observation: the synchronised rails give ALL_DATA (every sum digit and the carry has exactly one rail high) and ALL_NULL (all rails low).
  - A condition is accepted only after it holds for 2 consecutive synchronised samples.
  - Detection latency from ring edge is SYNC_STAGES+1 cycles.
- IDLE: ack=1.
  - Leave on a rising edge of run, or on a step pulse, provided ALL_NULL is seen → WAIT_DATA with ack=0.
  - run and step in the same cycle: run wins (free-run).
  - step outside IDLE is ignored.
- WAIT_DATA: ack=0.
  - On ALL_DATA with the buffer free (cnt_valid=0, or cnt_valid&cnt_ready this cycle): latch cnt_value (rail1 per bit) and cnt_ovf, set cnt_valid next cycle → REQ_NULL.
  - Buffer full: stay, ack held 0. DATA is held in the ring (backpressure); the watchdog is frozen while stalled on the buffer.
- REQ_NULL: ack=1.
  - On ALL_NULL: if step-mode or hit condition or run=0 → IDLE; else → WAIT_DATA.
- Hit: compare at latch time; hit pulses in the cycle cnt_valid rises.
  - After a hit, the controller stays in IDLE until a new run rising edge or step, even if run remains high.
- Buffer: single entry. cnt_valid drops on cnt_valid&cnt_ready unless refilled in the same cycle. Value and ovf are stable while valid and not ready.
- Watchdog: counts cycles in WAIT_DATA/REQ_NULL and resets on each state change.
  - Reaching TIMEOUT → ERROR, err=1.
  - Any digit with rails 2'b11 in any state → ERROR, err=2. Simultaneous conditions: ILLEGAL has priority.
- ERROR: ack=1, busy=0, cnt_valid keeps its pending value until consumed. Exit only via init.
- init mid-operation: outputs return to reset values immediately (async); the pending value is lost.

Decomposition:
- Package ncl_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_DATA, REQ_NULL, ERROR);
  - err code constants;
  - functions dr_all_data, dr_all_null, dr_illegal, dr_to_bin over 2*WIDTH vectors.
- Sub-module ncl_dr_sync_detect: per-rail SYNC_STAGES synchroniser, 2-sample stability filter, and the ALL_DATA/ALL_NULL/ILLEGAL/value outputs.

Test Plan:
1. Ring model counting from 0, run=1, cnt_ready=1 → cnt_value 0,1,2,3 each delivered exactly once; sum_ack toggles once per value; busy=1.
2. cnt_ready=0 after value 2 for 200 cycles → sum_ack stays 0, no err, no value lost; cnt_ready=1 → values 2 then 3 in order.
3. run=0, single step pulse → exactly one value delivered, then IDLE with sum_ack=1, busy=0; step during REQ_NULL is ignored.
4. target=5, target_en=1, run=1 held → values 0..5, hit pulses with cnt_value=5, then IDLE; run toggled 0→1 → next value 6.
5. Model presents 0xFFFFFFFF then wrap with carry DATA1 → cnt_value 0x00000000, cnt_ovf=1.
6. Model never completes bit 7 → err=1 after TIMEOUT cycles, sum_ack=1; force digit 3 to 2'b11 → err=2; assert init mid-WAIT_DATA → all outputs at reset values within the same cycle.
